// File: rtl/wb_arbiter.sv
// wb_arbiter: N-master to 1-slave Wishbone B4 pipelined arbiter with
// registered round-robin grant and per-grant outstanding tracking.
//
// Ports:
//   clk, rst (async, active low)
//   m_cyc/m_stb/m_we/m_adr/m_dat_w/m_sel  : flattened master requests
//   m_ack/m_err/m_stall                   : per-master responses
//   m_dat_r                               : read data, shared by all masters
//   s_cyc/s_stb/s_we/s_adr/s_dat_w/s_sel  : slave request
//   s_ack/s_stall/s_dat_r                 : slave response
//
// Optional: define ARB_TIMEOUT_EN to enable the ack watchdog that
// raises m_err after TIMEOUT_CYCLES idle cycles with requests pending.
module wb_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_cyc,
  input  logic [NUM_MASTERS-1:0]          m_stb,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_w,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [NUM_MASTERS-1:0]          m_err,
  output logic [NUM_MASTERS-1:0]          m_stall,
  output logic [DATA_W-1:0]               m_dat_r,
  output logic                            s_cyc,
  output logic                            s_stb,
  output logic                            s_we,
  output logic [ADDR_W-1:0]               s_adr,
  output logic [DATA_W-1:0]               s_dat_w,
  output logic [DATA_W/8-1:0]             s_sel,
  input  logic                            s_ack,
  input  logic                            s_stall,
  input  logic [DATA_W-1:0]               s_dat_r
);

  localparam int GW = $clog2(NUM_MASTERS);
  localparam int SW = DATA_W / 8;
  localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [GW-1:0] r_grant_idx;
  logic [GW-1:0] w_grant_nx;
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] w_rr_nx;
  logic [GW-1:0] w_pick;
  logic [GW-1:0] w_idx;
  logic [GW-1:0] w_grant_p1;
  logic [3:0]    r_outst;
  logic [3:0]    w_outst_nx;

  logic w_any_req;
  logic w_active;
  logic w_own_cyc;
  logic w_own_stb;
  logic w_full;
  logic w_accept;
  logic w_ack_ok;
  logic w_release;
  logic w_to_hit;

  assign w_active   = (r_state == S_ACTIVE);
  assign w_own_cyc  = m_cyc[r_grant_idx];
  assign w_own_stb  = m_stb[r_grant_idx];
  assign w_full     = (r_outst >= MAX_O);
  assign w_grant_p1 = GW'((int'(r_grant_idx) + 1) % NUM_MASTERS);

  // Slave request path is a pure mux on the registered grant.
  assign s_we    = m_we[r_grant_idx];
  assign s_adr   = m_adr[int'(r_grant_idx)*ADDR_W +: ADDR_W];
  assign s_dat_w = m_dat_w[int'(r_grant_idx)*DATA_W +: DATA_W];
  assign s_sel   = m_sel[int'(r_grant_idx)*SW +: SW];
  assign m_dat_r = s_dat_r;

  assign w_accept  = s_stb && !s_stall;
  assign w_ack_ok  = w_active && s_ack && (r_outst != 4'd0) && !w_to_hit;
  // Dropping cyc while requests are in flight is an abort: the
  // counter is simply discarded together with the grant.
  assign w_release = w_active && (!w_own_cyc || w_to_hit);

  // First requester at or after rr_ptr; scanning from the far end
  // lets the nearest one win.
  always_comb begin
    w_pick    = '0;
    w_idx     = '0;
    w_any_req = 1'b0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      w_idx = GW'((int'(r_rr_ptr) + k) % NUM_MASTERS);
      if (m_cyc[w_idx]) begin
        w_pick    = w_idx;
        w_any_req = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] r_wdog;
  logic [TW-1:0] w_wdog_nx;

  // The count includes the cycle of the last accept/ack, so the
  // error lands exactly TIMEOUT_CYCLES cycles after it.
  assign w_to_hit = w_active && (r_wdog == TO_LIM);

  always_comb begin
    w_wdog_nx = '0;
    if (w_active && !w_release) begin
      if (w_accept || w_ack_ok)
        w_wdog_nx = TW'(1);
      else if (r_outst != 4'd0)
        w_wdog_nx = r_wdog + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_wdog <= '0;
    else
      r_wdog <= w_wdog_nx;
  end
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES > 0);
  assign w_to_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_outst     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_grant_idx <= w_grant_nx;
      r_rr_ptr    <= w_rr_nx;
      r_outst     <= w_outst_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant_idx;
    w_rr_nx    = r_rr_ptr;
    w_outst_nx = r_outst;
    unique case (r_state)
      S_IDLE: begin
        w_outst_nx = '0;
        if (w_any_req) begin
          w_state_nx = S_ACTIVE;
          w_grant_nx = w_pick;
        end
      end
      S_ACTIVE: begin
        if (w_release) begin
          w_state_nx = S_IDLE;
          w_rr_nx    = w_grant_p1;
          w_outst_nx = '0;
        end else begin
          w_outst_nx = r_outst + 4'(w_accept) - 4'(w_ack_ok);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    m_stall = '1;
    m_ack   = '0;
    m_err   = '0;
    if (w_active) begin
      s_cyc = w_own_cyc && !w_to_hit;
      s_stb = w_own_cyc && w_own_stb && !w_full && !w_to_hit;
      m_stall[r_grant_idx] = s_stall || w_full || w_to_hit;
      m_ack[r_grant_idx]   = w_ack_ok;
      m_err[r_grant_idx]   = w_to_hit;
    end
  end

endmodule
